// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: FSM state encoding, opcode field layout,
// halt opcode and PC increment.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned OPCODE_MSB  = 31;
    localparam int unsigned OPCODE_LSB  = 26;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;
    localparam logic [15:0] PC_INCR     = 16'd4;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Load captures a fetched word, bubble clears
// only the valid bit (instruction/address are kept), otherwise it holds.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] fetch_instr,
    input  logic [15:0] fetch_pc,
    output logic [31:0] instr,
    output logic [15:0] pc,
    output logic        valid
);

    // Register update: load has priority over bubble; neither means hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= fetch_instr;
            pc    <= fetch_pc;
            valid <= 1'b1;
        end else if (bubble) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control FSM and the
// IF/ID register. Program memory is external and read combinationally.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] P_RESET_PC    = 16'h0000,
    parameter logic [5:0]  P_HALT_OPCODE = HALT_OPCODE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_target,
    input  logic [31:0] i_instruction,
    output logic [15:0] o_pc_address,
    output logic [31:0] o_if_id_instr,
    output logic [15:0] o_if_id_pc,
    output logic        o_if_id_valid,
    output logic        o_halted,
    output logic        o_misaligned
);

    fetch_state_t state, next_state;
    logic [15:0]  pc, pc_next;
    logic         ifid_load, ifid_bubble, mis_set;
    logic [15:0]  redirect_pc;

    assign redirect_pc = {i_branch_target[15:2], 2'b00};

    // Next-state, next-PC and IF/ID control; redirect beats stall beats advance.
    always_comb begin
        next_state  = state;
        pc_next     = pc;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        mis_set     = 1'b0;
        case (state)
            ST_BOOT: begin
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (i_branch_taken) begin
                    pc_next     = redirect_pc;
                    ifid_bubble = 1'b1;
                    mis_set     = |i_branch_target[1:0];
                end else if (!i_stall) begin
                    ifid_load = 1'b1;
                    if (opcode_of(i_instruction) == P_HALT_OPCODE) begin
                        next_state = ST_HALT;
                    end else begin
                        pc_next = pc + PC_INCR;
                    end
                end
            end
            ST_HALT: begin
                if (i_branch_taken) begin
                    pc_next     = redirect_pc;
                    ifid_bubble = 1'b1;
                    mis_set     = |i_branch_target[1:0];
                    next_state  = ST_RUN;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end
            default: begin
                next_state = ST_BOOT;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_BOOT;
            pc    <= P_RESET_PC;
        end else begin
            state <= next_state;
            pc    <= pc_next;
        end
    end

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_misaligned <= 1'b0;
        end else if (mis_set) begin
            o_misaligned <= 1'b1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (i_clk),
        .rst         (i_rst),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .fetch_instr (i_instruction),
        .fetch_pc    (pc),
        .instr       (o_if_id_instr),
        .pc          (o_if_id_pc),
        .valid       (o_if_id_valid)
    );

    assign o_pc_address = pc;
    assign o_halted     = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural model pushes expected outputs to a
// scoreboard when each cycle's inputs are driven; they are popped and
// compared one time unit after the clock edge.
module tb_fetch_stage;

    logic        i_clk;
    logic        i_rst;
    logic        i_stall;
    logic        i_branch_taken;
    logic [15:0] i_branch_target;
    logic [31:0] i_instruction;
    logic [15:0] o_pc_address;
    logic [31:0] o_if_id_instr;
    logic [15:0] o_if_id_pc;
    logic        o_if_id_valid;
    logic        o_halted;
    logic        o_misaligned;

    fetch_stage #(
        .P_RESET_PC    (16'h0000),
        .P_HALT_OPCODE (6'b111111)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_instruction   (i_instruction),
        .o_pc_address    (o_pc_address),
        .o_if_id_instr   (o_if_id_instr),
        .o_if_id_pc      (o_if_id_pc),
        .o_if_id_valid   (o_if_id_valid),
        .o_halted        (o_halted),
        .o_misaligned    (o_misaligned)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Program memory (word addressed by byte address [15:2]).
    logic [31:0] mem [0:16383];
    assign i_instruction = mem[o_pc_address[15:2]];

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] instr;
        logic [15:0] ifpc;
        logic        valid;
        logic        halted;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 = BOOT, 1 = RUN, 2 = HALT.
    int          m_state;
    logic [15:0] m_pc;
    logic [31:0] m_instr;
    logic [15:0] m_ifpc;
    logic        m_valid;
    logic        m_mis;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 16'h0000;
        m_instr = '0;
        m_ifpc  = '0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic model_cycle(input logic stall, input logic br, input logic [15:0] tgt);
        logic [31:0] word;
        word = mem[m_pc[15:2]];
        if (m_state == 0) begin
            m_state = 1;
        end else if (br) begin
            m_pc    = {tgt[15:2], 2'b00};
            m_valid = 1'b0;
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
            m_state = 1;
        end else if (m_state == 2) begin
            m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = word;
            m_ifpc  = m_pc;
            m_valid = 1'b1;
            if (word[31:26] == 6'b111111) m_state = 2;
            else                          m_pc = m_pc + 16'd4;
        end
    endtask

    task automatic step(input logic stall, input logic br, input logic [15:0] tgt, input string tag);
        exp_t e;
        exp_t got;
        @(negedge i_clk);
        i_stall         = stall;
        i_branch_taken  = br;
        i_branch_target = tgt;
        model_cycle(stall, br, tgt);
        e.pc = m_pc; e.instr = m_instr; e.ifpc = m_ifpc;
        e.valid = m_valid; e.halted = (m_state == 2); e.mis = m_mis;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        got = sb.pop_front();
        check_val({tag, "_pc"},     32'(o_pc_address),  32'(got.pc));
        check_val({tag, "_instr"},  o_if_id_instr,      got.instr);
        check_val({tag, "_ifpc"},   32'(o_if_id_pc),    32'(got.ifpc));
        check_val({tag, "_valid"},  32'(o_if_id_valid), 32'(got.valid));
        check_val({tag, "_halted"}, 32'(o_halted),      32'(got.halted));
        check_val({tag, "_mis"},    32'(o_misaligned),  32'(got.mis));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pc"},     32'(o_pc_address),  32'h0);
        check_val({tag, "_instr"},  o_if_id_instr,      32'h0);
        check_val({tag, "_ifpc"},   32'(o_if_id_pc),    32'h0);
        check_val({tag, "_valid"},  32'(o_if_id_valid), 32'h0);
        check_val({tag, "_halted"}, 32'(o_halted),      32'h0);
        check_val({tag, "_mis"},    32'(o_misaligned),  32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[0] = 32'h8020000A;
        mem[1] = 32'h04400800;
        mem[2] = 32'h0C600800;
        mem[3] = 32'h10800004;
        i_rst = 1'b1; i_stall = 1'b0; i_branch_taken = 1'b0; i_branch_target = '0;

        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs("reset");
        i_rst = 1'b0;
        model_reset();

        // Sequential fetch
        step(1'b0, 1'b0, 16'h0, "boot");
        check_val("boot_valid0", 32'(o_if_id_valid), 32'h0);
        step(1'b0, 1'b0, 16'h0, "seq0");
        check_val("seq0_word", o_if_id_instr, 32'h8020000A);
        check_val("seq0_addr", 32'(o_if_id_pc), 32'h0);
        step(1'b0, 1'b0, 16'h0, "seq1");
        check_val("seq1_word", o_if_id_instr, 32'h04400800);
        check_val("seq1_pc8", 32'(o_pc_address), 32'h8);

        // Stall three cycles at PC 8
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0, "stall");
            check_val("stall_pc_frozen", 32'(o_pc_address), 32'h8);
            check_val("stall_ifpc_frozen", 32'(o_if_id_pc), 32'h4);
        end
        step(1'b0, 1'b0, 16'h0, "seq2");
        check_val("seq2_word", o_if_id_instr, 32'h0C600800);
        check_val("seq2_addr", 32'(o_if_id_pc), 32'h8);

        // Redirect with stall to a misaligned target
        step(1'b1, 1'b1, 16'h0042, "redir");
        check_val("redir_pc40", 32'(o_pc_address), 32'h40);
        check_val("redir_bubble", 32'(o_if_id_valid), 32'h0);
        check_val("redir_mis", 32'(o_misaligned), 32'h1);
        step(1'b0, 1'b0, 16'h0, "post_redir");
        check_val("post_redir_ifpc", 32'(o_if_id_pc), 32'h40);

        // PC wrap
        step(1'b0, 1'b1, 16'hFFFC, "to_fffc");
        step(1'b0, 1'b0, 16'h0, "wrap");
        check_val("wrap_pc0", 32'(o_pc_address), 32'h0);
        check_val("wrap_ifpc", 32'(o_if_id_pc), 32'hFFFC);

        // Halt at 0x000C
        mem[3] = 32'hFC000000;
        step(1'b0, 1'b1, 16'h000C, "to_halt");
        step(1'b0, 1'b0, 16'h0, "halt_in");
        check_val("halt_in_valid", 32'(o_if_id_valid), 32'h1);
        check_val("halt_in_halted", 32'(o_halted), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(i[0], 1'b0, 16'h0, "halted");
            check_val("halted_pcC", 32'(o_pc_address), 32'hC);
            check_val("halted_valid0", 32'(o_if_id_valid), 32'h0);
        end
        step(1'b1, 1'b1, 16'h0000, "resume");
        check_val("resume_halted0", 32'(o_halted), 32'h0);
        step(1'b0, 1'b0, 16'h0, "resume_run");
        step(1'b0, 1'b1, 16'h000C, "to_halt2");
        step(1'b0, 1'b0, 16'h0, "halt2");

        // Asynchronous reset mid-cycle in HALT
        #2;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge i_clk);
        #1;
        check_reset_outputs("rst_hold");
        i_rst = 1'b0;
        model_reset();

        // Redirect during BOOT is ignored
        step(1'b0, 1'b1, 16'h0022, "boot_br");
        check_val("boot_br_pc0", 32'(o_pc_address), 32'h0);
        check_val("boot_br_mis0", 32'(o_misaligned), 32'h0);
        step(1'b0, 1'b0, 16'h0, "reboot0");

        // Randomised traffic
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom();
            if ($urandom_range(7) == 0) mem[i][31:26] = 6'b111111;
            else if (mem[i][31:26] == 6'b111111) mem[i][31:26] = 6'b000001;
        end
        for (int i = 0; i < 120; i++) begin
            logic st, br;
            logic [15:0] tg;
            st = ($urandom_range(2) == 0);
            br = ($urandom_range(5) == 0);
            tg = 16'($urandom_range(255));
            step(st, br, tg, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter P_RESET_PC, default 16'h0000, as the first fetch address after reset.
REQ-002 The block SHALL have parameter P_HALT_OPCODE, default 6'b111111, as the instruction[31:26] value that halts fetch.
REQ-003 Port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1: asynchronous, active-high reset.
REQ-005 Port i_stall, input, 1: hazard hold from decode; PC and IF/ID hold.
REQ-006 Port i_branch_taken, input, 1: redirect request from execute.
REQ-007 Port i_branch_target, input, 16: redirect byte address.
REQ-008 Port i_instruction, input, 32: program-memory read data for o_pc_address, combinational, same cycle.
REQ-009 Port o_pc_address, output, 16: byte address driven to program memory, registered.
REQ-010 Port o_if_id_instr, output, 32: IF/ID instruction register.
REQ-011 Port o_if_id_pc, output, 16: IF/ID address of o_if_id_instr.
REQ-012 Port o_if_id_valid, output, 1: IF/ID contents are a real instruction, not a bubble.
REQ-013 Port o_halted, output, 1: high while the FSM is in HALT.
REQ-014 Port o_misaligned, output, 1: sticky flag, set by any redirect with i_branch_target[1:0] != 0.

Function
REQ-015 FSM states SHALL be BOOT, RUN and HALT, encoded in 2 bits.
REQ-016 BOOT SHALL last exactly one cycle after reset release, with o_if_id_valid=0 and PC held, then go to RUN unconditionally.
REQ-017 In RUN, when no stall or redirect is active, each cycle SHALL:
- latch i_instruction into o_if_id_instr;
- latch o_pc_address into o_if_id_pc;
- set o_if_id_valid=1;
- advance PC by 4.
REQ-018 PC arithmetic SHALL be 16-bit modulo: 16'hFFFC+4 gives 16'h0000, with no flag.
REQ-019 Fetch latency SHALL be one cycle: an address presented in cycle n appears on o_if_id_* in cycle n+1.
REQ-020 Priority SHALL be, from highest to lowest: i_rst, then i_branch_taken, then i_stall, then normal advance.
REQ-021 When i_branch_taken=1, in any state other than BOOT, the block SHALL:
- load PC with {i_branch_target[15:2],2'b00};
- clear o_if_id_valid (bubble) while leaving o_if_id_instr and o_if_id_pc unchanged;
- move HALT to RUN.
REQ-022 i_branch_taken=1 together with i_stall=1 SHALL act as a redirect; the stall is ignored that cycle.
REQ-023 i_stall=1 without a redirect SHALL hold PC, o_if_id_instr, o_if_id_pc and o_if_id_valid unchanged.
REQ-024 When a fetched word in RUN has [31:26]==P_HALT_OPCODE, is unstalled and is not redirected, the block SHALL:
- latch that word into IF/ID with o_if_id_valid=1;
- hold PC at the halt address;
- enter HALT.
REQ-025 In HALT, o_if_id_valid SHALL be 0 from the following cycle onward, PC SHALL hold, and i_stall SHALL have no effect.
REQ-026 i_branch_taken in BOOT SHALL be ignored.
REQ-027 o_misaligned SHALL clear only on reset.

Reset
REQ-028 Asserting i_rst at any time, including mid-redirect or in HALT, SHALL immediately force:
- state=BOOT;
- o_pc_address=P_RESET_PC;
- o_if_id_instr=32'h0, o_if_id_pc=16'h0, o_if_id_valid=0;
- o_halted=0, o_misaligned=0.
REQ-029 Outputs SHALL hold their reset values for as long as i_rst=1.

Structure
REQ-030 The FSM state enum, opcode field positions, the halt opcode and the PC increment constant (4) SHALL live in the shared package cpu_pkg.
REQ-031 One sub-module, if_id_reg, SHALL hold the IF/ID register with load, bubble and hold controls; the PC register and FSM SHALL remain in fetch_stage.
REQ-032 The block SHALL contain no memory; it SHALL connect to the program memory only through o_pc_address and i_instruction.

Verification
REQ-033 Sequential fetch: reset, release, memory holds 32'h8020000A@0, 32'h04400800@4, 32'h0C600800@8.
- Cycle 1 (BOOT): o_if_id_valid=0.
- Cycles 2-4: those instructions appear on o_if_id_instr with o_if_id_pc=0, 4, 8.
REQ-034 Stall: assert i_stall for 3 cycles while o_pc_address=8 -> o_pc_address and o_if_id_* frozen for those 3 cycles; fetch resumes at 8.
REQ-035 Redirect: assert i_branch_taken=1 with i_stall=1 and i_branch_target=16'h0042.
- Next cycle: o_pc_address=16'h0040, o_if_id_valid=0, o_misaligned=1.
- The cycle after: o_if_id_pc=16'h0040.
REQ-036 Wrap: force PC to 16'hFFFC via redirect -> next o_pc_address=16'h0000.
REQ-037 Halt: word 32'hFC000000 fetched at 16'h000C.
- o_if_id_valid=1 for one cycle, then 0.
- o_halted=1 and PC stays 16'h000C indefinitely.
- A later i_branch_taken to 16'h0000 resumes RUN.
REQ-038 Async reset: assert i_rst mid-cycle in HALT -> all outputs reach reset values before the next clock edge, and the BOOT cycle repeats after release.
